// File: rtl/rt_pkg.sv
// Shared types and constants for the RTcore framebuffer writer.
package rt_pkg;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int FB_ADDR_W = 17;
  localparam int IDX_W     = 19;

  typedef logic [3:0] pixel_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [15:0]          data;
    logic [3:0]           nmask;
  } fb_entry_t;

  typedef enum logic {WR_IDLE, WR_WRITE} wr_state_t;

  // Y*640 + X as two shifts and an add; Y < 480 keeps the sum inside 19 bits.
  function automatic logic [IDX_W-1:0] lin_index(input logic [9:0] x, input logic [8:0] y);
    logic [IDX_W-1:0] yy;
    yy = {10'd0, y};
    return (yy << 9) + (yy << 7) + {9'd0, x};
  endfunction

endpackage

// File: rtl/rt_fb_fifo.sv
// Small synchronous FIFO of packed framebuffer words; exposes head and the entry behind it.
module rt_fb_fifo
  import rt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      CLK,
  input  logic      RESET,
  input  logic      push,
  input  logic      pop,
  input  fb_entry_t wdata,
  output logic      full,
  output logic      empty,
  output logic      multi,
  output fb_entry_t head,
  output fb_entry_t head_nxt
);

  localparam int PW = $clog2(DEPTH);

  fb_entry_t     mem [DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr, count;
  logic [PW-1:0] rd_idx, rd_nxt;
  logic          do_push, do_pop;

  assign count    = wr_ptr - rd_ptr;
  assign full     = count == (PW+1)'(DEPTH);
  assign empty    = count == '0;
  assign multi    = count > (PW+1)'(1);
  assign rd_idx   = rd_ptr[PW-1:0];
  assign rd_nxt   = rd_idx + 1'b1;
  assign head     = mem[rd_idx];
  assign head_nxt = mem[rd_nxt];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge CLK)
    if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;

endmodule

// File: rtl/rt_fb_writer.sv
// Packs 4-bit pixels into 16-bit framebuffer words and writes them to SRAM.
// Optional RT_FB_PIXEL_COUNT_EN adds a saturating accepted-pixel counter output.
module rt_fb_writer
  import rt_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PIXEL_VALID,
  input  logic [9:0]        PIXEL_X,
  input  logic [8:0]        PIXEL_Y,
  input  pixel_t            PIXEL,
  input  logic              FLUSH,
  output logic              PIXEL_ACCEPT,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [15:0]       MEM_DATA,
  output logic [3:0]        MEM_NMASK,
  input  logic              MEM_ACK,
  output logic              FRAME_DONE,
  output logic              OVERFLOW,
  output logic              COORD_ERR
`ifdef RT_FB_PIXEL_COUNT_EN
  ,output logic [18:0]      PIXEL_COUNT
`endif
);

  localparam logic [9:0]        X_LIM     = 10'(H_RES);
  localparam logic [8:0]        Y_LIM     = 9'(V_RES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((H_RES * V_RES - 1) / 4);

  // accumulator
  logic [ADDR_W-1:0] acc_addr;
  logic [15:0]       acc_data;
  logic [3:0]        acc_mask;
  logic              pend;

  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] px_addr;
  logic [1:0]        px_nib;
  logic              in_range, take, acc_empty, same;
  logic [15:0]       mrg_data;
  logic [3:0]        mrg_mask;

  logic      push, acc_clr, acc_load, pend_set, pend_clr;
  fb_entry_t push_e;

  logic      fifo_full, fifo_empty, fifo_multi, pop;
  fb_entry_t head, head_nxt;

  wr_state_t state;
  logic      frame_hit;

  assign idx       = lin_index(PIXEL_X, PIXEL_Y);
  assign px_addr   = ADDR_W'(idx >> 2);
  assign px_nib    = idx[1:0];
  assign in_range  = (PIXEL_X < X_LIM) && (PIXEL_Y < Y_LIM);

  assign PIXEL_ACCEPT = !fifo_full && !pend;
  assign take         = PIXEL_VALID && PIXEL_ACCEPT && in_range;
  assign acc_empty    = acc_mask == 4'h0;
  assign same         = !acc_empty && (px_addr == acc_addr);

  // When the pixel starts a new word, same=0 makes the merge the fresh word.
  for (genvar n = 0; n < 4; n++) begin : g_nib
    logic hit;
    assign hit                = px_nib == 2'(n);
    assign mrg_data[4*n +: 4] = hit ? PIXEL : (same ? acc_data[4*n +: 4] : 4'h0);
    assign mrg_mask[n]        = hit | (same & acc_mask[n]);
  end

  always_comb begin
    push         = 1'b0;
    push_e.addr  = acc_addr;
    push_e.data  = acc_data;
    push_e.nmask = acc_mask;
    acc_clr      = 1'b0;
    acc_load     = 1'b0;
    pend_set     = 1'b0;
    pend_clr     = 1'b0;
    if (pend) begin
      if (!fifo_full) begin
        push     = 1'b1;
        acc_clr  = 1'b1;
        pend_clr = 1'b1;
      end
    end else if (take) begin
      if (!acc_empty && !same) begin
        // Old partial word goes now; a second push for the new word waits a cycle.
        push     = 1'b1;
        acc_load = 1'b1;
        pend_set = (px_nib == 2'd3) || FLUSH;
      end else if ((px_nib == 2'd3) || FLUSH) begin
        push         = 1'b1;
        push_e.addr  = px_addr;
        push_e.data  = mrg_data;
        push_e.nmask = mrg_mask;
        acc_clr      = 1'b1;
      end else begin
        acc_load = 1'b1;
      end
    end else if (FLUSH && !acc_empty) begin
      if (!fifo_full) begin
        push    = 1'b1;
        acc_clr = 1'b1;
      end else begin
        pend_set = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_addr  <= '0;
      acc_data  <= '0;
      acc_mask  <= '0;
      pend      <= 1'b0;
      OVERFLOW  <= 1'b0;
      COORD_ERR <= 1'b0;
    end else begin
      if (acc_clr) begin
        acc_addr <= '0;
        acc_data <= '0;
        acc_mask <= '0;
      end else if (acc_load) begin
        acc_addr <= px_addr;
        acc_data <= mrg_data;
        acc_mask <= mrg_mask;
      end
      if (pend_set)      pend <= 1'b1;
      else if (pend_clr) pend <= 1'b0;
      if (PIXEL_VALID && !PIXEL_ACCEPT) OVERFLOW  <= 1'b1;
      if (PIXEL_VALID && !in_range)     COORD_ERR <= 1'b1;
    end
  end

  rt_fb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK      (CLK),
    .RESET    (RESET),
    .push     (push),
    .pop      (pop),
    .wdata    (push_e),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .multi    (fifo_multi),
    .head     (head),
    .head_nxt (head_nxt)
  );

  assign pop       = (state == WR_WRITE) && MEM_ACK;
  assign frame_hit = pop && (MEM_ADDR == LAST_ADDR);

  // Write port is registered; on ack the entry behind the head is presented next.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= WR_IDLE;
      MEM_WE     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_DATA   <= '0;
      MEM_NMASK  <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= frame_hit;
      case (state)
        WR_IDLE: begin
          if (!fifo_empty) begin
            state     <= WR_WRITE;
            MEM_WE    <= 1'b1;
            MEM_ADDR  <= head.addr;
            MEM_DATA  <= head.data;
            MEM_NMASK <= head.nmask;
          end
        end
        WR_WRITE: begin
          if (MEM_ACK) begin
            if (fifo_multi) begin
              MEM_ADDR  <= head_nxt.addr;
              MEM_DATA  <= head_nxt.data;
              MEM_NMASK <= head_nxt.nmask;
            end else begin
              state  <= WR_IDLE;
              MEM_WE <= 1'b0;
            end
          end
        end
        default: begin
          state  <= WR_IDLE;
          MEM_WE <= 1'b0;
        end
      endcase
    end
  end

`ifdef RT_FB_PIXEL_COUNT_EN
  always_ff @(posedge CLK) begin
    if (RESET || frame_hit)
      PIXEL_COUNT <= '0;
    else if (take && (PIXEL_COUNT != '1))
      PIXEL_COUNT <= PIXEL_COUNT + 19'd1;
  end
`else
  // Counter and its port are absent in this build.
`endif

endmodule

// File: tb/tb_rt_fb_writer.sv
// Self-checking bench for rt_fb_writer: directed cases plus randomized traffic vs. a word-level model.
module tb_rt_fb_writer;
  import rt_pkg::*;

  localparam int D = 4;
  localparam logic [16:0] LAST = 17'd76799;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        PIXEL_VALID = 1'b0;
  logic [9:0]  PIXEL_X = '0;
  logic [8:0]  PIXEL_Y = '0;
  logic [3:0]  PIXEL = '0;
  logic        FLUSH = 1'b0;
  logic        MEM_ACK = 1'b0;
  logic        PIXEL_ACCEPT, MEM_WE, FRAME_DONE, OVERFLOW, COORD_ERR;
  logic [16:0] MEM_ADDR;
  logic [15:0] MEM_DATA;
  logic [3:0]  MEM_NMASK;
`ifdef RT_FB_PIXEL_COUNT_EN
  logic [18:0] PIXEL_COUNT;
`endif

  rt_fb_writer dut (
    .CLK(CLK), .RESET(RESET), .PIXEL_VALID(PIXEL_VALID), .PIXEL_X(PIXEL_X),
    .PIXEL_Y(PIXEL_Y), .PIXEL(PIXEL), .FLUSH(FLUSH), .PIXEL_ACCEPT(PIXEL_ACCEPT),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_NMASK(MEM_NMASK),
    .MEM_ACK(MEM_ACK), .FRAME_DONE(FRAME_DONE), .OVERFLOW(OVERFLOW), .COORD_ERR(COORD_ERR)
`ifdef RT_FB_PIXEL_COUNT_EN
    , .PIXEL_COUNT(PIXEL_COUNT)
`endif
  );

  always #10 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  // Model: words waiting for (or being) written, plus the open partial word.
  fb_entry_t   q[$];
  logic [16:0] m_addr = '0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_mask = '0;
  bit m_pend = 0, m_ovf = 0, m_cerr = 0, m_fd = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    bit full, ok, inr, pop, has_push, fd_n;
    int idx, n;
    logic [16:0] a;
    fb_entry_t cur, pe;
    if (chk_en) begin
      cmp("accept", PIXEL_ACCEPT, (q.size() < D) && !m_pend);
      cmp("overflow", OVERFLOW, m_ovf);
      cmp("coord_err", COORD_ERR, m_cerr);
      cmp("frame_done", FRAME_DONE, m_fd);
      if (MEM_WE) begin
        if (q.size() == 0) cmp("we_without_word", MEM_WE, 0);
        else begin
          cmp("wr_addr", MEM_ADDR, q[0].addr);
          cmp("wr_data", MEM_DATA, q[0].data);
          cmp("wr_nmask", MEM_NMASK, q[0].nmask);
        end
      end
    end
    if (RESET) begin
      q.delete();
      m_addr = '0; m_data = '0; m_mask = '0;
      m_pend = 0; m_ovf = 0; m_cerr = 0; m_fd = 0;
    end else begin
      full = q.size() >= D;
      ok   = !full && !m_pend;
      inr  = (PIXEL_X < 640) && (PIXEL_Y < 480);
      pop  = MEM_WE && MEM_ACK && (q.size() > 0);
      fd_n = pop && (q[0].addr == LAST);
      if (PIXEL_VALID && !inr) m_cerr = 1;
      if (PIXEL_VALID && !ok)  m_ovf = 1;
      has_push = 0;
      cur.addr = m_addr; cur.data = m_data; cur.nmask = m_mask;
      pe = cur;
      if (m_pend) begin
        if (!full) begin
          has_push = 1; m_pend = 0;
          m_addr = '0; m_data = '0; m_mask = '0;
        end
      end else if (PIXEL_VALID && ok && inr) begin
        idx = int'(PIXEL_Y) * 640 + int'(PIXEL_X);
        a = 17'(idx / 4);
        n = int'(PIXEL_X) % 4;
        if (m_mask != 0 && a != m_addr) begin
          has_push = 1;
          m_addr = a;
          m_data = 16'(PIXEL) << (4 * n);
          m_mask = 4'(1 << n);
          if (n == 3 || FLUSH) m_pend = 1;
        end else begin
          m_addr = a;
          m_data = (m_data & ~(16'hF << (4 * n))) | (16'(PIXEL) << (4 * n));
          m_mask = m_mask | 4'(1 << n);
          if (n == 3 || FLUSH) begin
            has_push = 1;
            pe.addr = m_addr; pe.data = m_data; pe.nmask = m_mask;
            m_addr = '0; m_data = '0; m_mask = '0;
          end
        end
      end else if (FLUSH && m_mask != 0) begin
        if (!full) begin
          has_push = 1;
          m_addr = '0; m_data = '0; m_mask = '0;
        end else m_pend = 1;
      end
      if (pop) void'(q.pop_front());
      if (has_push) q.push_back(pe);
      m_fd = fd_n;
    end
  end

  task automatic step(input bit v, input int x, input int y, input int p, input bit f);
    PIXEL_VALID = v; PIXEL_X = 10'(x); PIXEL_Y = 9'(y); PIXEL = 4'(p); FLUSH = f;
    @(posedge CLK); #1;
    PIXEL_VALID = 0; FLUSH = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic wait_write(input string nm, input int a, input int d, input int m);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (MEM_WE && MEM_ACK) begin
        seen = 1;
        cmp({nm, "_addr"}, MEM_ADDR, a);
        cmp({nm, "_data"}, MEM_DATA, d);
        cmp({nm, "_nmask"}, MEM_NMASK, m);
      end
      @(posedge CLK); #1;
    end
    cmp({nm, "_seen"}, seen, 1);
  endtask

  initial begin
    bit v, f, seen;
    int x, y;
    @(posedge CLK); #1;
    chk_en = 1;
    idle(1);
    cmp("rst_we", MEM_WE, 0);
    cmp("rst_accept", PIXEL_ACCEPT, 1);
    cmp("rst_addr", MEM_ADDR, 0);
    RESET = 0;
    idle(1);

    // four adjacent pixels -> one full word, two cycles after the last strobe
    MEM_ACK = 1;
    for (int k = 0; k < 4; k++) step(1, k, 0, k + 1, 0);
    cmp("row_we_early", MEM_WE, 0);
    idle(1);
    cmp("row_we", MEM_WE, 1);
    cmp("row_addr", MEM_ADDR, 0);
    cmp("row_data", MEM_DATA, 16'h4321);
    cmp("row_nmask", MEM_NMASK, 4'hF);
    idle(2);

    // skipped pixel, then flush of the second partial word
    step(1, 320, 240, 5, 0);
    step(1, 325, 240, 7, 0);
    wait_write("skip0", 38480, 16'h0005, 4'h1);
    step(0, 0, 0, 0, 1);
    wait_write("skip1", 38481, 16'h0070, 4'h2);

    // new word completing on its first pixel -> one-cycle stall
    step(1, 4, 0, 9, 0);
    step(1, 7, 1, 10, 0);
    cmp("pend_accept_low", PIXEL_ACCEPT, 0);
    idle(1);
    cmp("pend_accept_back", PIXEL_ACCEPT, 1);
    wait_write("pend0", 1, 16'h0009, 4'h1);
    wait_write("pend1", 161, 16'hA000, 4'h8);
    idle(2);

    // backpressure: ack held low, five words offered
    cmp("ovf_before", OVERFLOW, 0);
    MEM_ACK = 0;
    for (int w = 0; w < 5; w++)
      for (int k = 0; k < 4; k++) step(1, w * 4 + k, 10, k + 1, 0);
    cmp("bp_accept", PIXEL_ACCEPT, 0);
    step(1, 20, 10, 1, 0);
    cmp("bp_overflow", OVERFLOW, 1);
    MEM_ACK = 1;
    wait_write("bp0", 1600, 16'h4321, 4'hF);
    idle(8);

    // bounds and end of frame
    step(1, 640, 0, 3, 0);
    cmp("oor_cerr", COORD_ERR, 1);
    idle(4);
    cmp("oor_no_we", MEM_WE, 0);
    for (int k = 0; k < 4; k++) step(1, 636 + k, 479, k + 1, 0);
    wait_write("last", 76799, 16'h4321, 4'hF);
    cmp("frame_done_pulse", FRAME_DONE, 1);
    idle(1);
    cmp("frame_done_end", FRAME_DONE, 0);

    // reset while a write is outstanding
    MEM_ACK = 0;
    for (int k = 0; k < 4; k++) step(1, k, 5, 6, 0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (MEM_WE) seen = 1; else idle(1);
    end
    cmp("rstw_we_seen", seen, 1);
    RESET = 1;
    idle(1);
    RESET = 0;
    cmp("rstw_we", MEM_WE, 0);
    cmp("rstw_accept", PIXEL_ACCEPT, 1);
    cmp("rstw_ovf", OVERFLOW, 0);
    idle(2);

    // randomized traffic around the left and bottom-right corners of the frame
    for (int i = 0; i < 3000; i++) begin
      MEM_ACK = $urandom_range(0, 9) < 6;
      v = $urandom_range(0, 9) < 7;
      f = $urandom_range(0, 19) == 0;
      x = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(632, 645));
      y = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(478, 481));
      RESET = (i % 1000) == 999;
      step(v, x, y, int'($urandom_range(0, 15)), f);
      RESET = 0;
    end

    // drain everything still buffered
    MEM_ACK = 1;
    idle(2);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 60 && (q.size() != 0 || m_pend); i++) idle(1);
    cmp("drain_left", q.size(), 0);
    idle(2);
    cmp("drain_we", MEM_WE, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
